// File: rtl/stopwatch_display_scheduler.sv
// stopwatch_display_scheduler: maps VGA pixel coordinates onto an eight-cell
// MM:SS.cc seven-segment layout, rendering from a per-frame digit snapshot
// captured through a valid/ready handshake at frame start.
// Optional feature macro: STOPWATCH_SEP_BLINK_EN (blinking separator dots).
module stopwatch_display_scheduler #(
    parameter int unsigned INIT_OFFSET_X = 56,
    parameter int unsigned INIT_OFFSET_Y = 208,
    parameter int unsigned CELL_W        = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [23:0] digits_in,
    input  logic        digits_valid,
    output logic        digits_ready,
    output logic        pix_on,
    output logic        pix_on_valid
);

    localparam int unsigned CW        = 11;
    localparam int unsigned CELL_H    = 56;
    localparam int unsigned NUM_CELLS = 8;
    localparam int unsigned LXW       = $clog2(CELL_W);
    localparam int unsigned REGION_W  = NUM_CELLS * CELL_W;

    // Cell index is taken by shifting, so the pitch must be a power of two
    // wide enough to hold the 32-pixel glyph.
    if ((CELL_W < 32) || ((CELL_W & (CELL_W - 1)) != 0)) begin : g_cell_w_check
        $error("CELL_W must be a power of two and at least 32");
    end

    typedef enum logic {
        ST_DISPLAY = 1'b0,
        ST_SNAP    = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        capture;
    logic [23:0] shadow;

    logic [CW-1:0]  x_ext;
    logic [CW-1:0]  y_ext;
    logic           in_x;
    logic           in_y;
    logic [2:0]     cell_c;
    logic [LXW-1:0] lx_c;
    logic [5:0]     ly_c;
    logic [3:0]     digit_c;

    logic           s1_valid;
    logic           s1_in;
    logic [2:0]     s1_cell;
    logic [LXW-1:0] s1_lx;
    logic [5:0]     s1_ly;
    logic [3:0]     s1_digit;

    logic [CW-1:0]  lx_w;
    logic [CW-1:0]  ly_w;
    logic [6:0]     seg_pat;
    logic [6:0]     seg_hit;
    logic           dot_hit;
    logic           sep_on;
    logic           lit;

    function automatic logic in_rng(input logic [CW-1:0] v,
                                    input logic [CW-1:0] lo,
                                    input logic [CW-1:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

    // Segment pattern {a,b,c,d,e,f,g}; non-decimal nibbles render blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h7E;
            4'd1:    return 7'h30;
            4'd2:    return 7'h6D;
            4'd3:    return 7'h79;
            4'd4:    return 7'h33;
            4'd5:    return 7'h5B;
            4'd6:    return 7'h5F;
            4'd7:    return 7'h70;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h7B;
            default: return 7'h00;
        endcase
    endfunction

    // Snapshot FSM state and registered ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_DISPLAY;
            digits_ready <= 1'b0;
        end else begin
            state        <= state_next;
            digits_ready <= (state_next == ST_SNAP);
        end
    end

    // Snapshot FSM next-state: arm on frame start, close on handshake.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            ST_DISPLAY: begin
                if (frame_start) state_next = ST_SNAP;
            end
            ST_SNAP: begin
                if (digits_valid) begin
                    capture    = 1'b1;
                    state_next = ST_DISPLAY;
                end
            end
            default: state_next = ST_DISPLAY;
        endcase
    end

    // Shadow digits: only changes on a completed handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= 24'h000000;
        end else if (capture) begin
            shadow <= digits_in;
        end
    end

`ifdef STOPWATCH_SEP_BLINK_EN
    logic [5:0] blink_cnt;

    // Frame counter modulo 60 driving the one-second separator blink.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= 6'd0;
        end else if (frame_start) begin
            blink_cnt <= (blink_cnt == 6'd59) ? 6'd0 : blink_cnt + 6'd1;
        end
    end

    assign sep_on = (blink_cnt < 6'd30);
`else
    assign sep_on = 1'b1;
`endif

    // Stage 1 combinational: region test, cell index, local coords, digit pick.
    always_comb begin
        x_ext  = CW'(x);
        y_ext  = CW'(y);
        in_x   = (x_ext >= CW'(INIT_OFFSET_X)) && (x_ext < CW'(INIT_OFFSET_X + REGION_W));
        in_y   = (y_ext >= CW'(INIT_OFFSET_Y)) && (y_ext < CW'(INIT_OFFSET_Y + CELL_H));
        cell_c = 3'((x_ext - CW'(INIT_OFFSET_X)) >> LXW);
        lx_c   = LXW'(x_ext - CW'(INIT_OFFSET_X));
        ly_c   = 6'(y_ext - CW'(INIT_OFFSET_Y));
        case (cell_c)
            3'd0:    digit_c = shadow[23:20];
            3'd1:    digit_c = shadow[19:16];
            3'd3:    digit_c = shadow[15:12];
            3'd4:    digit_c = shadow[11:8];
            3'd6:    digit_c = shadow[7:4];
            3'd7:    digit_c = shadow[3:0];
            default: digit_c = 4'hF;
        endcase
    end

    // Stage 1 registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_in    <= 1'b0;
            s1_cell  <= 3'd0;
            s1_lx    <= '0;
            s1_ly    <= 6'd0;
            s1_digit <= 4'd0;
        end else begin
            s1_valid <= pix_valid;
            s1_in    <= pix_valid && in_x && in_y;
            s1_cell  <= cell_c;
            s1_lx    <= lx_c;
            s1_ly    <= ly_c;
            s1_digit <= digit_c;
        end
    end

    // Stage 2 combinational: segment and separator hit test.
    always_comb begin
        lx_w    = CW'(s1_lx);
        ly_w    = CW'(s1_ly);
        seg_pat = seg_decode(s1_digit);
        seg_hit = {
            in_rng(lx_w, 11'd8,  11'd24) && in_rng(ly_w, 11'd0,  11'd8),
            in_rng(lx_w, 11'd24, 11'd32) && in_rng(ly_w, 11'd8,  11'd24),
            in_rng(lx_w, 11'd24, 11'd32) && in_rng(ly_w, 11'd32, 11'd48),
            in_rng(lx_w, 11'd8,  11'd24) && in_rng(ly_w, 11'd48, 11'd56),
            in_rng(lx_w, 11'd0,  11'd8)  && in_rng(ly_w, 11'd32, 11'd48),
            in_rng(lx_w, 11'd0,  11'd8)  && in_rng(ly_w, 11'd8,  11'd24),
            in_rng(lx_w, 11'd8,  11'd24) && in_rng(ly_w, 11'd24, 11'd32)
        };
        dot_hit = in_rng(lx_w, 11'd12, 11'd20) &&
                  (in_rng(ly_w, 11'd16, 11'd24) || in_rng(ly_w, 11'd32, 11'd40));
        if ((s1_cell == 3'd2) || (s1_cell == 3'd5)) begin
            lit = dot_hit && sep_on;
        end else begin
            lit = |(seg_pat & seg_hit);
        end
    end

    // Stage 2 registers: final pixel flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_on       <= 1'b0;
            pix_on_valid <= 1'b0;
        end else begin
            pix_on       <= s1_in && lit;
            pix_on_valid <= s1_valid;
        end
    end

endmodule

// File: tb/tb_stopwatch_display_scheduler.sv
// Directed self-checking bench for stopwatch_display_scheduler.
module tb_stopwatch_display_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        pix_valid;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] digits_in;
    logic        digits_valid;
    logic        digits_ready;
    logic        pix_on;
    logic        pix_on_valid;

    int passed = 0;
    int total  = 0;

    stopwatch_display_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .x            (x),
        .y            (y),
        .digits_in    (digits_in),
        .digits_valid (digits_valid),
        .digits_ready (digits_ready),
        .pix_on       (pix_on),
        .pix_on_valid (pix_on_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one pixel and return the result two cycles later.
    task automatic pix(input int px, input int py, output logic on, output logic v);
        x = 10'(px);
        y = 10'(py);
        pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        step();
        on = pix_on;
        v  = pix_on_valid;
    endtask

    task automatic snap(input logic [23:0] val);
        frame_start = 1'b1;
        step();
        frame_start  = 1'b0;
        digits_in    = val;
        digits_valid = 1'b1;
        step();
        digits_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; x = '0; y = '0;
        digits_in = '0; digits_valid = 1'b0;
        step(); step();
        reset = 1'b0;
        total++; if (digits_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", digits_ready); else passed++;
        total++; if (pix_on !== 1'b0) $display("FAIL rst_pix_on: got %b want 0", pix_on); else passed++;
        total++; if (pix_on_valid !== 1'b0) $display("FAIL rst_pix_valid: got %b want 0", pix_on_valid); else passed++;
    endtask

    task automatic test_latency();
        x = 10'd68; y = 10'd210; pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        total++; if (pix_on_valid !== 1'b0) $display("FAIL lat_early: got %b want 0", pix_on_valid); else passed++;
        step();
        total++; if (pix_on_valid !== 1'b1) $display("FAIL lat_valid: got %b want 1", pix_on_valid); else passed++;
        total++; if (pix_on !== 1'b1) $display("FAIL lat_seg_a0: got %b want 1", pix_on); else passed++;
        step();
        total++; if (pix_on_valid !== 1'b0) $display("FAIL lat_drop: got %b want 0", pix_on_valid); else passed++;
        // pipeline flushed by reset
        x = 10'd68; y = 10'd210; pix_valid = 1'b1;
        step();
        pix_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (pix_on_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", pix_on_valid); else passed++;
        total++; if (pix_on !== 1'b0) $display("FAIL flush_on: got %b want 0", pix_on); else passed++;
    endtask

    task automatic test_capture();
        logic on, v;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        total++; if (digits_ready !== 1'b1) $display("FAIL cap_ready_hi: got %b want 1", digits_ready); else passed++;
        digits_in = 24'h123456; digits_valid = 1'b1;
        step();
        digits_valid = 1'b0;
        total++; if (digits_ready !== 1'b0) $display("FAIL cap_ready_lo: got %b want 0", digits_ready); else passed++;
        pix(308, 248, on, v);
        total++; if (on !== 1'b1 || v !== 1'b1) $display("FAIL cap_c_of_6: got %b/%b want 1/1", on, v); else passed++;
        pix(92, 220, on, v);
        total++; if (on !== 1'b0) $display("FAIL cap_f_of_2: got %b want 0", on); else passed++;
        pix(68, 210, on, v);
        total++; if (on !== 1'b0) $display("FAIL cap_a_of_1: got %b want 0", on); else passed++;
        pix(84, 220, on, v);
        total++; if (on !== 1'b1) $display("FAIL cap_b_of_1: got %b want 1", on); else passed++;
    endtask

    task automatic test_no_frame();
        logic on, v;
        digits_in = 24'h999999; digits_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (digits_ready !== 1'b0) $display("FAIL noframe_ready[%0d]: got %b want 0", i, digits_ready); else passed++;
            digits_valid = ~digits_valid;
        end
        digits_valid = 1'b0;
        pix(68, 210, on, v);
        total++; if (on !== 1'b0) $display("FAIL noframe_shadow: got %b want 0", on); else passed++;
    endtask

    task automatic test_double_frame();
        logic on, v;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        total++; if (digits_ready !== 1'b1) $display("FAIL dbl_ready: got %b want 1", digits_ready); else passed++;
        pix(68, 210, on, v);
        total++; if (on !== 1'b0) $display("FAIL dbl_old_digits: got %b want 0", on); else passed++;
        total++; if (digits_ready !== 1'b1) $display("FAIL dbl_still_snap: got %b want 1", digits_ready); else passed++;
        digits_in = 24'h888888; digits_valid = 1'b1;
        step();
        digits_valid = 1'b0;
        total++; if (digits_ready !== 1'b0) $display("FAIL dbl_done: got %b want 0", digits_ready); else passed++;
        pix(68, 210, on, v);
        total++; if (on !== 1'b1) $display("FAIL dbl_new_a: got %b want 1", on); else passed++;
        pix(168, 236, on, v);
        total++; if (on !== 1'b1) $display("FAIL dbl_new_g: got %b want 1", on); else passed++;
    endtask

    task automatic test_boundary();
        logic on, v;
        int   px [8] = '{56, 55, 68, 68, 68, 68, 311, 312};
        int   py [8] = '{220, 220, 263, 264, 207, 208, 248, 248};
        logic ex [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            pix(px[i], py[i], on, v);
            total++;
            if (on !== ex[i] || v !== 1'b1)
                $display("FAIL bound(%0d,%0d): got %b/%b want %b/1", px[i], py[i], on, v, ex[i]);
            else passed++;
        end
    endtask

    task automatic test_bad_nibble();
        logic on, v;
        int   lit_cnt = 0;
        int   val_cnt = 0;
        snap(24'hA00000);
        for (int ly = 0; ly < 56; ly++) begin
            for (int lx = 0; lx < 32; lx++) begin
                pix(56 + lx, 208 + ly, on, v);
                if (on !== 1'b0) lit_cnt++;
                if (v === 1'b1) val_cnt++;
            end
        end
        total++; if (lit_cnt !== 0) $display("FAIL nibA_lit: got %0d want 0", lit_cnt); else passed++;
        total++; if (val_cnt !== 1792) $display("FAIL nibA_valid: got %0d want 1792", val_cnt); else passed++;
        pix(311, 248, on, v);
        total++; if (on !== 1'b1) $display("FAIL nibA_cell7: got %b want 1", on); else passed++;
    endtask

    task automatic test_reset_mid_snap();
        logic on, v;
        snap(24'h888888);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        total++; if (digits_ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", digits_ready); else passed++;
        digits_in = 24'h888888; digits_valid = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; digits_valid = 1'b0;
        total++; if (digits_ready !== 1'b0) $display("FAIL rmid_abort: got %b want 0", digits_ready); else passed++;
        step();
        total++; if (digits_ready !== 1'b0) $display("FAIL rmid_display: got %b want 0", digits_ready); else passed++;
        pix(168, 236, on, v);
        total++; if (on !== 1'b0) $display("FAIL rmid_zero_g: got %b want 0", on); else passed++;
        pix(68, 210, on, v);
        total++; if (on !== 1'b1) $display("FAIL rmid_zero_a: got %b want 1", on); else passed++;
    endtask

    task automatic test_separator();
        logic on, v;
        logic ex;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int f = 0; f <= 60; f++) begin
`ifdef STOPWATCH_SEP_BLINK_EN
            ex = ((f % 60) < 30);
`else
            ex = 1'b1;
`endif
            pix(136, 228, on, v);
            total++; if (on !== ex) $display("FAIL sep_dot_frame%0d: got %b want %b", f, on, ex); else passed++;
            if (f == 0) begin
                pix(136, 244, on, v);
                total++; if (on !== 1'b1) $display("FAIL sep_low_dot: got %b want 1", on); else passed++;
                pix(124, 228, on, v);
                total++; if (on !== 1'b0) $display("FAIL sep_off_dot: got %b want 0", on); else passed++;
            end
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_capture();
        test_no_frame();
        test_double_frame();
        test_boundary();
        test_bad_nibble();
        test_reset_mid_snap();
        test_separator();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
